ow_scratchpad_rx: RTL and testbench

OW_SCRATCHPAD_RX -- requirements
Module: ow_scratchpad_rx

---
 rtl/ow_pkg.sv | 21 ++
 rtl/ow_crc8.sv | 39 +++
 rtl/ow_scratchpad_rx.sv | 174 +++++++++++++++++
 tb/tb_ow_scratchpad_rx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ow_pkg.sv
// ow_pkg -- shared definitions for the 1-wire scratchpad receiver.
//   ow_state_t          : receiver FSM state encoding
//   OW_CRC8_POLY        : reflected Dallas/Maxim CRC8 polynomial (x^8+x^5+x^4+1)
//   OW_SCRATCHPAD_BYTES : bytes in a DS18B20-style scratchpad read
//   ow_crc8_step        : one bit of the reflected CRC8
package ow_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } ow_state_t;

    localparam logic [7:0] OW_CRC8_POLY        = 8'h8C;
    localparam int         OW_SCRATCHPAD_BYTES = 9;

    function automatic logic [7:0] ow_crc8_step(input logic [7:0] crc, input logic b);
        ow_crc8_step = (crc >> 1) ^ ((crc[0] ^ b) ? OW_CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/ow_crc8.sv
// ow_crc8 -- bit-serial reflected Dallas CRC8 accumulator.
//   clk        : system clock
//   reset      : asynchronous active-high reset
//   i_clear    : synchronous clear (wins over i_enable)
//   i_enable   : fold i_bit into the CRC on this edge
//   i_bit      : serial data bit, LSB first
//   o_crc      : current CRC register
//   o_crc_next : CRC value after folding i_bit into o_crc
module ow_crc8
    import ow_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic       i_bit,
    output logic [7:0] o_crc,
    output logic [7:0] o_crc_next
);

    logic [7:0] r_crc;
    logic [7:0] w_crc_next;

    assign w_crc_next = ow_crc8_step(r_crc, i_bit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_crc <= 8'h00;
        end else if (i_clear) begin
            r_crc <= 8'h00;
        end else if (i_enable) begin
            r_crc <= w_crc_next;
        end
    end

    assign o_crc      = r_crc;
    assign o_crc_next = w_crc_next;

endmodule

// File: rtl/ow_scratchpad_rx.sv
// ow_scratchpad_rx -- assembles 1-wire read-slot bits into scratchpad bytes,
// reports each byte, and publishes {byte1, byte0} as the temperature word
// when a frame of NBYTES bytes completes.
//
// Optional feature macro: OW_CRC_CHECK_EN
//   defined   : CRC8 over the whole frame; temp updates only on a good CRC,
//               crc_err holds the result of the last completed frame.
//   undefined : no CRC logic, crc_err tied 0, temp updates on every frame.
//
// Ports
//   clk         : system clock (shared with the 1-wire master)
//   reset       : asynchronous active-high reset
//   frame_start : strobe, starts a new frame from any state
//   bit_valid   : strobe, bit_data holds a sampled bit
//   bit_data    : sampled bit, LSB first
//   byte_data   : last assembled byte
//   byte_valid  : one-cycle strobe when byte_data updates
//   byte_idx    : index of byte_data within the frame
//   temp        : {byte1, byte0} of the last accepted frame
//   temp_valid  : one-cycle strobe at frame completion
//   crc_err     : CRC failure of the last completed frame (level)
//   busy        : high while collecting
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_IDLE    | after reset, waiting for frame_start, bits ignored
// ST_COLLECT | shifting bits in, counting bits and bytes
// ST_DONE    | frame complete, bits ignored until frame_start
module ow_scratchpad_rx
    import ow_pkg::*;
#(
    parameter int NBYTES = OW_SCRATCHPAD_BYTES
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        bit_valid,
    input  logic        bit_data,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic [3:0]  byte_idx,
    output logic [15:0] temp,
    output logic        temp_valid,
    output logic        crc_err,
    output logic        busy
);

    localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

    ow_state_t   r_state;
    ow_state_t   w_state_nxt;

    logic [2:0]  r_bit_cnt;
    logic [3:0]  r_byte_cnt;
    logic [7:0]  r_sr;
    logic [7:0]  r_byte0;
    logic [7:0]  r_byte1;
    logic [7:0]  r_byte_data;
    logic        r_byte_valid;
    logic [3:0]  r_byte_idx;
    logic [15:0] r_temp;
    logic        r_temp_valid;

    logic        w_take_bit;
    logic        w_byte_done;
    logic        w_frame_done;
    logic [7:0]  w_new_byte;
    logic [7:0]  w_byte1;
    logic        w_crc_ok;

    // frame_start wins over a coincident bit, which is then dropped
    assign w_take_bit   = (r_state == ST_COLLECT) && bit_valid && !frame_start;
    assign w_byte_done  = w_take_bit && (r_bit_cnt == 3'd7);
    assign w_frame_done = w_byte_done && (r_byte_cnt == LAST_IDX);
    assign w_new_byte   = {bit_data, r_sr[7:1]};
    // with a 2-byte frame, byte 1 is the byte completing right now
    assign w_byte1      = (r_byte_cnt == 4'd1) ? w_new_byte : r_byte1;

`ifdef OW_CRC_CHECK_EN
    logic [7:0] w_crc;
    logic [7:0] w_crc_next;
    logic [7:0] w_residue;
    logic       r_crc_err;

    ow_crc8 u_crc8 (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (frame_start),
        .i_enable   (w_take_bit),
        .i_bit      (bit_data),
        .o_crc      (w_crc),
        .o_crc_next (w_crc_next)
    );

    // the residue must include the final bit being sampled this edge
    assign w_residue = w_take_bit ? w_crc_next : w_crc;
    assign w_crc_ok  = (w_residue == 8'h00);
    assign crc_err   = r_crc_err;
`else
    assign w_crc_ok  = 1'b1;
    assign crc_err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (frame_start) begin
            w_state_nxt = ST_COLLECT;
        end else if (w_frame_done) begin
            w_state_nxt = ST_DONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt    <= 3'd0;
            r_byte_cnt   <= 4'd0;
            r_sr         <= 8'h00;
            r_byte0      <= 8'h00;
            r_byte1      <= 8'h00;
            r_byte_data  <= 8'h00;
            r_byte_valid <= 1'b0;
            r_byte_idx   <= 4'd0;
            r_temp       <= 16'h0000;
            r_temp_valid <= 1'b0;
`ifdef OW_CRC_CHECK_EN
            r_crc_err    <= 1'b0;
`endif
        end else begin
            r_byte_valid <= 1'b0;
            r_temp_valid <= 1'b0;
            if (frame_start) begin
                r_bit_cnt  <= 3'd0;
                r_byte_cnt <= 4'd0;
                r_sr       <= 8'h00;
            end else if (w_take_bit) begin
                r_sr      <= w_new_byte;
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (w_byte_done) begin
                    r_byte_data  <= w_new_byte;
                    r_byte_idx   <= r_byte_cnt;
                    r_byte_valid <= 1'b1;
                    if (r_byte_cnt == 4'd0) r_byte0 <= w_new_byte;
                    if (r_byte_cnt == 4'd1) r_byte1 <= w_new_byte;
                    if (r_byte_cnt != LAST_IDX) begin
                        r_byte_cnt <= r_byte_cnt + 4'd1;
                    end else begin
                        r_temp_valid <= 1'b1;
                        if (w_crc_ok) r_temp <= {w_byte1, r_byte0};
`ifdef OW_CRC_CHECK_EN
                        r_crc_err <= !w_crc_ok;
`endif
                    end
                end
            end
        end
    end

    assign byte_data  = r_byte_data;
    assign byte_valid = r_byte_valid;
    assign byte_idx   = r_byte_idx;
    assign temp       = r_temp;
    assign temp_valid = r_temp_valid;
    assign busy       = (r_state == ST_COLLECT);

endmodule

// File: tb/tb_ow_scratchpad_rx.sv
module tb_ow_scratchpad_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_data = 1'b0;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic [3:0]  byte_idx;
    logic [15:0] temp;
    logic        temp_valid;
    logic        crc_err;
    logic        busy;

    always #5 clk = ~clk;

    ow_scratchpad_rx #(.NBYTES(9)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .bit_valid   (bit_valid),
        .bit_data    (bit_data),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_idx    (byte_idx),
        .temp        (temp),
        .temp_valid  (temp_valid),
        .crc_err     (crc_err),
        .busy        (busy)
    );

    typedef struct packed {
        logic [71:0] frame;
        logic [15:0] exp_temp;
        logic        exp_err;
    } vec_t;

    vec_t        tbl [5];
    int          checks = 0;
    int          errors = 0;
    int          bv_count = 0;
    int          tv_count = 0;
    logic [7:0]  cap [16];

    localparam logic [71:0] GOOD = {8'h1C, 8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, 8'h05, 8'h50};

    // outputs are registered on posedge, so the falling edge sees them stable
    always @(negedge clk) begin
        if (byte_valid) begin
            bv_count++;
            cap[byte_idx] = byte_data;
        end
        if (temp_valid) begin
            tv_count++;
            checks++;
            if (!(byte_valid && byte_idx == 4'd8)) begin
                errors++;
                $display("FAIL tv_with_last_byte byte_valid=%0b byte_idx=%0d required 1/8", byte_valid, byte_idx);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] crc_calc(input logic [71:0] f, input int n);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < n; i++)
            c = (c >> 1) ^ ((c[0] ^ f[i]) ? 8'h8C : 8'h00);
        return c;
    endfunction

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_data  = b;
        @(negedge clk);
        bit_valid = 1'b0;
        bit_data  = 1'b0;
    endtask

    task automatic send_bits(input logic [71:0] f, input int n);
        for (int i = 0; i < n; i++) send_bit(f[i]);
    endtask

    task automatic start(input logic bv, input logic bd);
        frame_start = 1'b1;
        bit_valid   = bv;
        bit_data    = bd;
        @(negedge clk);
        frame_start = 1'b0;
        bit_valid   = 1'b0;
        bit_data    = 1'b0;
    endtask

    task automatic clear_cap();
        for (int k = 0; k < 16; k++) cap[k] = 8'hxx;
    endtask

    task automatic check_frame(input logic [71:0] f, input int bv0, input int tv0,
                               input logic [15:0] et, input logic ee);
        @(negedge clk);
        check("frame_byte_valid_count", bv_count - bv0, 9);
        check("frame_temp_valid_count", tv_count - tv0, 1);
        for (int k = 0; k < 9; k++) check("frame_byte", {24'd0, cap[k]}, {24'd0, f[8*k +: 8]});
        check("frame_byte_idx", {28'd0, byte_idx}, 8);
        check("frame_byte_data", {24'd0, byte_data}, {24'd0, f[71:64]});
        check("frame_temp", {16'd0, temp}, {16'd0, et});
        check("frame_crc_err", {31'd0, crc_err}, {31'd0, ee});
        check("frame_busy_after", {31'd0, busy}, 0);
    endtask

    initial begin
        int b0;
        int t0;
        int bpre;
        logic [71:0] f2;

        f2 = {8'h00, 64'h100FFF7F464B0191};
        f2[71:64] = crc_calc(f2, 64);

        tbl[0] = '{frame: GOOD, exp_temp: 16'h0550, exp_err: 1'b0};
`ifdef OW_CRC_CHECK_EN
        tbl[1] = '{frame: {GOOD[71:24], 8'h4A, GOOD[15:0]}, exp_temp: 16'h0550, exp_err: 1'b1};
`else
        tbl[1] = '{frame: {GOOD[71:24], 8'h4A, GOOD[15:0]}, exp_temp: 16'h0550, exp_err: 1'b0};
`endif
        tbl[2] = '{frame: f2, exp_temp: 16'h0191, exp_err: 1'b0};
        tbl[3] = '{frame: 72'd0, exp_temp: 16'h0000, exp_err: 1'b0};
`ifdef OW_CRC_CHECK_EN
        tbl[4] = '{frame: {GOOD[71:8], 8'h51}, exp_temp: 16'h0000, exp_err: 1'b1};
`else
        tbl[4] = '{frame: {GOOD[71:8], 8'h51}, exp_temp: 16'h0551, exp_err: 1'b0};
`endif
        clear_cap();

        // reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {byte_data, byte_valid, byte_idx, temp, temp_valid, crc_err, busy}, 0);
        reset = 1'b0;
        @(negedge clk);

        // bits in IDLE are ignored
        b0 = bv_count;
        send_bits(GOOD, 16);
        @(negedge clk);
        check("idle_ignore_bv", bv_count - b0, 0);
        check("idle_busy", {31'd0, busy}, 0);

        // table-driven complete frames
        for (int i = 0; i < 5; i++) begin
            clear_cap();
            start(1'b0, 1'b0);
            check("collect_busy", {31'd0, busy}, 1);
            b0 = bv_count;
            t0 = tv_count;
            send_bits(tbl[i].frame, 72);
            check_frame(tbl[i].frame, b0, t0, tbl[i].exp_temp, tbl[i].exp_err);
        end

        // frame abandoned after 37 bits, then a good frame
        clear_cap();
        bpre = bv_count;
        t0   = tv_count;
        start(1'b0, 1'b0);
        send_bits(GOOD, 37);
        check("partial_busy", {31'd0, busy}, 1);
        start(1'b0, 1'b0);
        check("partial_bv_count", bv_count - bpre, 4);
        check("partial_no_tv", tv_count - t0, 0);
        check("partial_temp_hold", {16'd0, temp}, {16'd0, tbl[4].exp_temp});
        check("partial_err_hold", {31'd0, crc_err}, {31'd0, tbl[4].exp_err});
        b0 = bv_count;
        t0 = tv_count;
        send_bits(GOOD, 72);
        check_frame(GOOD, b0, t0, 16'h0550, 1'b0);

        // extra bits after completion are ignored
        b0 = bv_count;
        t0 = tv_count;
        send_bits(GOOD, 10);
        @(negedge clk);
        check("done_ignore_bv", bv_count - b0, 0);
        check("done_ignore_tv", tv_count - t0, 0);
        check("done_busy", {31'd0, busy}, 0);

        // frame_start with a coincident bit: that bit is dropped
        clear_cap();
        start(1'b1, 1'b1);
        b0 = bv_count;
        t0 = tv_count;
        send_bits(GOOD, 72);
        check_frame(GOOD, b0, t0, 16'h0550, 1'b0);

        // asynchronous reset mid-byte
        start(1'b0, 1'b0);
        send_bits(GOOD, 3);
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs", {byte_data, byte_valid, byte_idx, temp, temp_valid, crc_err, busy}, 0);
        @(negedge clk);
        reset = 1'b0;
        b0 = bv_count;
        send_bits(GOOD, 16);
        @(negedge clk);
        check("post_reset_ignore_bv", bv_count - b0, 0);
        check("post_reset_busy", {31'd0, busy}, 0);
        clear_cap();
        start(1'b0, 1'b0);
        b0 = bv_count;
        t0 = tv_count;
        send_bits(GOOD, 72);
        check_frame(GOOD, b0, t0, 16'h0550, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
